// File: rtl/adder_accumulator_ctrl.sv
// adder_accumulator_ctrl
// Command front-end for an external combinational 8-bit adder. It accepts
// LOAD/ADD/SUB/CLRFLAGS commands, drives the adder from latched command
// registers, keeps an 8-bit accumulator and a sticky signed-overflow flag,
// and returns one response per command over a valid/ready handshake.
module adder_accumulator_ctrl #(
   parameter logic SATURATE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_operand,
   output logic [7:0] add_a,
   output logic [7:0] add_b,
   output logic       add_opcode,
   output logic       add_cin,
   input  logic [7:0] add_sum,
   input  logic       add_cout,
   input  logic       add_overflow,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_acc,
   output logic       rsp_cout,
   output logic       rsp_ovf,
   output logic [7:0] acc,
   output logic       sticky_ovf,
   output logic       busy
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state, nstate;
   logic [1:0] op_q;
   logic [7:0] opnd_q;
   logic       is_arith;
   logic       sat_hit;
   logic [7:0] result;

   // State register; reset abandons any in-flight command or response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   // Next state and handshake outputs; ready/valid depend on state only,
   // so there is no combinational path from cmd_valid or rsp_ready.
   always_comb begin
      nstate    = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) nstate = EXEC;
         end
         EXEC: nstate = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   // Latch the command on acceptance; held stable through EXEC and RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_LOAD;
         opnd_q <= 8'h00;
      end else if (state == IDLE && cmd_valid) begin
         op_q   <= cmd_op;
         opnd_q <= cmd_operand;
      end
   end

   // Adder drive: LOAD is 0+operand, CLRFLAGS is acc+0, SUB is acc+~b+1.
   always_comb begin
      add_a      = (op_q == OP_LOAD) ? 8'h00 : acc;
      add_b      = (op_q == OP_CLR)  ? 8'h00 : opnd_q;
      add_opcode = (op_q == OP_SUB);
      add_cin    = (op_q == OP_SUB);
   end

   // Result select; on overflow the sign of operand a gives the clamp direction.
   always_comb begin
      is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
      sat_hit  = SATURATE && is_arith && add_overflow;
      result   = add_sum;
      if (sat_hit) result = add_a[7] ? 8'h80 : 8'h7F;
   end

   // Commit accumulator, response and sticky flag at the end of EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= 8'h00;
         rsp_acc    <= 8'h00;
         rsp_cout   <= 1'b0;
         rsp_ovf    <= 1'b0;
         sticky_ovf <= 1'b0;
      end else if (state == EXEC) begin
         acc      <= result;
         rsp_acc  <= result;
         rsp_cout <= add_cout;
         rsp_ovf  <= add_overflow;
         if (op_q == OP_CLR)                sticky_ovf <= 1'b0;
         else if (is_arith && add_overflow) sticky_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
// Bench for adder_accumulator_ctrl: a wrapping and a saturating instance run
// side by side on one command stream, each with its own adder model.
module tb_adder_accumulator_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_operand = 8'h00;
   logic       rsp_ready = 1'b0;

   logic       cmd_ready0, cmd_ready1, rsp_valid0, rsp_valid1;
   logic [7:0] add_a0, add_a1, add_b0, add_b1, add_sum0, add_sum1;
   logic       add_opc0, add_opc1, add_cin0, add_cin1;
   logic       add_cout0, add_cout1, add_ovf0, add_ovf1;
   logic [7:0] rsp_acc0, rsp_acc1, acc0, acc1;
   logic       rsp_cout0, rsp_cout1, rsp_ovf0, rsp_ovf1;
   logic       sticky0, sticky1, busy0, busy1;

   // Stand-in for eightBit_adder: a + (opcode ? ~b : b) + cin.
   function automatic logic [9:0] adder(input logic [7:0] a, input logic [7:0] b,
                                        input logic opc, input logic cin);
      logic [7:0] bb;
      logic [8:0] s;
      bb = opc ? ~b : b;
      s  = {1'b0, a} + {1'b0, bb} + {8'h00, cin};
      return {s[8], (a[7] == bb[7]) && (s[7] != a[7]), s[7:0]};
   endfunction

   assign {add_cout0, add_ovf0, add_sum0} = adder(add_a0, add_b0, add_opc0, add_cin0);
   assign {add_cout1, add_ovf1, add_sum1} = adder(add_a1, add_b1, add_opc1, add_cin1);

   adder_accumulator_ctrl #(.SATURATE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
      .cmd_op(cmd_op), .cmd_operand(cmd_operand),
      .add_a(add_a0), .add_b(add_b0), .add_opcode(add_opc0), .add_cin(add_cin0),
      .add_sum(add_sum0), .add_cout(add_cout0), .add_overflow(add_ovf0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc0),
      .rsp_cout(rsp_cout0), .rsp_ovf(rsp_ovf0), .acc(acc0),
      .sticky_ovf(sticky0), .busy(busy0));

   adder_accumulator_ctrl #(.SATURATE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
      .cmd_op(cmd_op), .cmd_operand(cmd_operand),
      .add_a(add_a1), .add_b(add_b1), .add_opcode(add_opc1), .add_cin(add_cin1),
      .add_sum(add_sum1), .add_cout(add_cout1), .add_overflow(add_ovf1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc1),
      .rsp_cout(rsp_cout1), .rsp_ovf(rsp_ovf1), .acc(acc1),
      .sticky_ovf(sticky1), .busy(busy1));

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else pass_cnt++;
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
      else pass_cnt++;
   endtask

   // Reference model: signed/unsigned integer arithmetic on the command rules.
   logic [7:0] m_acc0 = 8'h00, m_acc1 = 8'h00;
   logic       m_sticky0 = 1'b0, m_sticky1 = 1'b0;

   task automatic model(input logic [1:0] op, input logic [7:0] opnd, input logic sat,
                        inout logic [7:0] macc, inout logic msticky,
                        output logic [7:0] racc, output logic rcout, output logic rovf);
      int sa, so, sr, ua, uo;
      sa = $signed(macc); so = $signed(opnd); ua = macc; uo = opnd;
      rcout = 1'b0; rovf = 1'b0; racc = macc; sr = 0;
      case (op)
         2'd0: racc = opnd;
         2'd1: begin sr = sa + so; rcout = (ua + uo) > 255; end
         2'd2: begin sr = sa - so; rcout = (ua >= uo); end
         default: msticky = 1'b0;
      endcase
      if (op == 2'd1 || op == 2'd2) begin
         rovf = (sr > 127) || (sr < -128);
         racc = sr[7:0];
         if (sat && rovf) racc = (sr > 127) ? 8'h7F : 8'h80;
         if (rovf) msticky = 1'b1;
      end
      macc = racc;
   endtask

   logic [7:0] g_acc0, g_acc1;
   logic       g_cout0, g_ovf0, g_ovf1, g_sticky0;

   // Issue one command, check it against the model, hold the response for
   // 'hold' cycles, then complete the handshake.
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] opnd, input int hold);
      int n;
      logic [7:0] e_acc0, e_acc1;
      logic e_cout0, e_ovf0, e_cout1, e_ovf1;
      n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd;
      while (!cmd_ready0 && n < 20) begin @(posedge clk); #1; n++; end
      if (!cmd_ready0) begin
         total_cnt++;
         $display("FAIL accept_timeout: cmd_ready stayed %b, required 1", cmd_ready0);
         cmd_valid = 1'b0;
         return;
      end
      model(op, opnd, 1'b0, m_acc0, m_sticky0, e_acc0, e_cout0, e_ovf0);
      model(op, opnd, 1'b1, m_acc1, m_sticky1, e_acc1, e_cout1, e_ovf1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk1("exec_cin", add_cin0, op == 2'd2);
      chk1("exec_busy", busy0, 1'b1);
      @(posedge clk); #1;
      chk1("rsp_valid0", rsp_valid0, 1'b1);
      chk1("rsp_valid1", rsp_valid1, 1'b1);
      chk8("rsp_acc0", rsp_acc0, e_acc0);
      chk1("rsp_cout0", rsp_cout0, e_cout0);
      chk1("rsp_ovf0", rsp_ovf0, e_ovf0);
      chk8("rsp_acc1", rsp_acc1, e_acc1);
      chk1("rsp_ovf1", rsp_ovf1, e_ovf1);
      chk8("acc0", acc0, e_acc0);
      chk1("sticky0", sticky0, m_sticky0);
      chk1("sticky1", sticky1, m_sticky1);
      g_acc0 = rsp_acc0; g_acc1 = rsp_acc1; g_cout0 = rsp_cout0;
      g_ovf0 = rsp_ovf0; g_ovf1 = rsp_ovf1; g_sticky0 = sticky0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk1("hold_valid", rsp_valid0, 1'b1);
         chk8("hold_acc", rsp_acc0, e_acc0);
         chk1("hold_ready", cmd_ready0, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk1("done_valid", rsp_valid0, 1'b0);
      chk1("done_ready", cmd_ready0, 1'b1);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [7:0] opnd;
      logic [7:0] acc0;
      logic       cout0;
      logic       ovf;
      logic [7:0] acc1;
      logic       sticky0;
   } vec_t;

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{2'd0, 8'h0A, 8'h0A, 1'b0, 1'b0, 8'h0A, 1'b0};
      vecs[1]  = '{2'd1, 8'h05, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0};
      vecs[2]  = '{2'd0, 8'h02, 8'h02, 1'b0, 1'b0, 8'h02, 1'b0};
      vecs[3]  = '{2'd2, 8'h05, 8'hFD, 1'b0, 1'b0, 8'hFD, 1'b0};
      vecs[4]  = '{2'd0, 8'h07, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0};
      vecs[5]  = '{2'd2, 8'h01, 8'h06, 1'b1, 1'b0, 8'h06, 1'b0};
      vecs[6]  = '{2'd0, 8'h88, 8'h88, 1'b0, 1'b0, 8'h88, 1'b0};
      vecs[7]  = '{2'd1, 8'h88, 8'h10, 1'b1, 1'b1, 8'h80, 1'b1};
      vecs[8]  = '{2'd3, 8'hFF, 8'h10, 1'b0, 1'b0, 8'h80, 1'b0};
      vecs[9]  = '{2'd0, 8'h64, 8'h64, 1'b0, 1'b0, 8'h64, 1'b0};
      vecs[10] = '{2'd2, 8'h9C, 8'hC8, 1'b0, 1'b1, 8'h7F, 1'b1};
      vecs[11] = '{2'd3, 8'h00, 8'hC8, 1'b0, 1'b0, 8'h7F, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_cmd_ready", cmd_ready0, 1'b1);
      chk1("rst_rsp_valid", rsp_valid0, 1'b0);
      chk1("rst_busy", busy0, 1'b0);
      chk8("rst_acc", acc0, 8'h00);
      chk8("rst_add_a", add_a0, 8'h00);
      chk8("rst_add_b", add_b0, 8'h00);
      chk1("rst_add_cin", add_cin0, 1'b0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_cmd(vecs[i].op, vecs[i].opnd, i % 3);
         chk8($sformatf("tbl%0d_acc0", i), g_acc0, vecs[i].acc0);
         chk1($sformatf("tbl%0d_cout0", i), g_cout0, vecs[i].cout0);
         chk1($sformatf("tbl%0d_ovf0", i), g_ovf0, vecs[i].ovf);
         chk8($sformatf("tbl%0d_acc1", i), g_acc1, vecs[i].acc1);
         chk1($sformatf("tbl%0d_ovf1", i), g_ovf1, vecs[i].ovf);
         chk1($sformatf("tbl%0d_sticky0", i), g_sticky0, vecs[i].sticky0);
      end

      // Backpressure with a pending command, then reset during its EXEC
      begin
         logic [7:0] r; logic c, o;
         model(2'd0, 8'h33, 1'b0, m_acc0, m_sticky0, r, c, o);
         model(2'd0, 8'h33, 1'b1, m_acc1, m_sticky1, r, c, o);
      end
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_operand = 8'h33;
      @(posedge clk); #1;
      cmd_op = 2'd1; cmd_operand = 8'h01;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         chk1("bp_valid", rsp_valid0, 1'b1);
         chk8("bp_rsp_acc", rsp_acc0, 8'h33);
         chk1("bp_cmd_ready", cmd_ready0, 1'b0);
         chk8("bp_acc", acc0, 8'h33);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk1("bp_idle_ready", cmd_ready0, 1'b1);
      chk8("bp_no_extra", acc0, 8'h33);
      @(posedge clk); #1;
      chk1("bp_exec_busy", busy0, 1'b1);
      #2 rst = 1'b1;
      #1;
      cmd_valid = 1'b0;
      chk8("arst_acc", acc0, 8'h00);
      chk1("arst_rsp_valid", rsp_valid0, 1'b0);
      chk1("arst_cmd_ready", cmd_ready0, 1'b1);
      chk1("arst_busy", busy0, 1'b0);
      chk8("arst_add_a", add_a0, 8'h00);
      chk8("arst_add_b", add_b0, 8'h00);
      chk8("arst_rsp_acc", rsp_acc0, 8'h00);
      chk1("arst_add_cin", add_cin0, 1'b0);
      chk8("arst_acc1", acc1, 8'h00);
      m_acc0 = 8'h00; m_acc1 = 8'h00; m_sticky0 = 1'b0; m_sticky1 = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("lost_rsp_valid", rsp_valid0, 1'b0);
      chk8("lost_acc", acc0, 8'h00);

      // Randomized stream against the reference model
      for (int i = 0; i < 60; i++)
         run_cmd(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule
